// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg : shared sizes, writer FSM encoding and count clamp helper |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mem_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 12;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int MAX_COUNT = DEPTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

  // Requests larger than the memory collapse to one full pass.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    return (c > (ADDR_W+1)'(MAX_COUNT)) ? (ADDR_W+1)'(MAX_COUNT) : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_stream_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_stream_writer_if : valid/ready word stream into the writer     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface ram_stream_writer_if;

  logic                        in_valid;
  logic [mem_pkg::DATA_W-1:0]  in_data;
  logic                        in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/ram_1kx12.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_1kx12 : 1024x12 RAM, sync write, registered read-before-write  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ram_1kx12
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_stream_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_stream_writer : writes a word stream to consecutive RAM slots  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ram_stream_writer
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       count,
  ram_stream_writer_if.slave    stream,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              w_fire;
  logic              w_launch;

  assign stream.in_ready = (r_state == WRITE);
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE);

  // The RAM write enable is the handshake itself; in_data goes straight in.
  assign w_fire   = stream.in_valid && (r_state == WRITE);
  assign w_launch = (r_state == IDLE) && start && (count != '0);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (w_fire && (r_remaining == (ADDR_W+1)'(1))) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_remaining <= '0;
    end else if (w_launch) begin
      r_wr_ptr    <= base_addr;
      r_remaining <= clamp_count(count);
    end else if (w_fire) begin
      r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
      r_remaining <= r_remaining - (ADDR_W+1)'(1);
    end
  end

  ram_1kx12 u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (w_fire),
    .wr_addr (r_wr_ptr),
    .wr_data (stream.in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire
